// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges per-stage stall requests into stall/flush vectors for the
// six pipeline registers (PC, IF, ID, EX, MEM, WB). It arbitrates the EX branch
// redirect against the MEM trap redirect. A redirect raised during a stall is
// held until the PC register can accept it. The module also keeps a free-running
// count of stalled cycles.
module pipe_ctrl #(
    localparam int XLEN = 32   // mirrors XLEN from sysconfig.v
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_stall_req_i,
    input  logic            id_stall_req_i,
    input  logic            ex_stall_req_i,
    input  logic            mem_stall_req_i,
    input  logic [XLEN-1:0] branch_pc_i,
    input  logic            branch_pc_valid_i,
    input  logic [XLEN-1:0] clint_pc_i,
    input  logic            clint_pc_valid_i,
    output logic [5:0]      stall_valid_o,
    output logic [5:0]      flush_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            redirect_valid_o,
    output logic [31:0]     stall_cycles_o
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Flush patterns for each redirect kind. A trap squashes IF..MEM.
    // A branch squashes only IF and ID.
    localparam logic [5:0] TRAP_FLUSH   = 6'b011110;
    localparam logic [5:0] BRANCH_FLUSH = 6'b000110;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic              pend_trap_q, pend_trap_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;

    logic [5:0]        stall_vec;
    logic [5:0]        bubble_vec;
    logic [5:0]        redir_flush;
    logic              stall_any;

    // The highest requesting stage freezes itself and everything upstream.
    // It also pushes a bubble into the stage just below it.
    always_comb begin
        stall_vec  = 6'b000000;
        bubble_vec = 6'b000000;
        if (mem_stall_req_i) begin
            stall_vec  = 6'b011111;
            bubble_vec = 6'b100000;
        end else if (ex_stall_req_i) begin
            stall_vec  = 6'b001111;
            bubble_vec = 6'b010000;
        end else if (id_stall_req_i) begin
            stall_vec  = 6'b000111;
            bubble_vec = 6'b001000;
        end else if (if_stall_req_i) begin
            stall_vec  = 6'b000011;
            bubble_vec = 6'b000100;
        end
        stall_any = if_stall_req_i | id_stall_req_i | ex_stall_req_i | mem_stall_req_i;
    end

    // Redirect arbitration and the RUN/HOLD next-state logic. A redirect only
    // leaves this block in an unstalled cycle, so the PC register is always
    // write-enabled when it sees one.
    always_comb begin
        state_d          = state_q;
        pend_pc_d        = pend_pc_q;
        pend_trap_d      = pend_trap_q;
        redir_flush      = 6'b000000;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        stall_valid_o    = 6'b000000;
        flush_valid_o    = 6'b000000;

        case (state_q)
            RUN: begin
                if (clint_pc_valid_i || branch_pc_valid_i) begin
                    if (!stall_any) begin
                        redirect_valid_o = 1'b1;
                        if (clint_pc_valid_i) begin
                            redirect_pc_o = clint_pc_i;
                            redir_flush   = TRAP_FLUSH;
                        end else begin
                            redirect_pc_o = branch_pc_i;
                            redir_flush   = BRANCH_FLUSH;
                        end
                    end else begin
                        state_d     = HOLD;
                        pend_trap_d = clint_pc_valid_i;
                        pend_pc_d   = clint_pc_valid_i ? clint_pc_i : branch_pc_i;
                    end
                end
            end
            HOLD: begin
                if (stall_any) begin
                    // Only a trap may replace the pending redirect. A later
                    // branch is on a path the trap or the older branch kills.
                    if (clint_pc_valid_i) begin
                        pend_pc_d   = clint_pc_i;
                        pend_trap_d = 1'b1;
                    end
                end else begin
                    state_d          = RUN;
                    redirect_valid_o = 1'b1;
                    if (clint_pc_valid_i) begin
                        redirect_pc_o = clint_pc_i;
                        redir_flush   = TRAP_FLUSH;
                    end else begin
                        redirect_pc_o = pend_pc_q;
                        redir_flush   = pend_trap_q ? TRAP_FLUSH : BRANCH_FLUSH;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        stall_valid_o = stall_vec;
        flush_valid_o = (redir_flush | bubble_vec) & ~stall_vec;

        // Hold every combinational output low while reset is asserted.
        if (!rst) begin
            stall_valid_o    = 6'b000000;
            flush_valid_o    = 6'b000000;
            redirect_valid_o = 1'b0;
            redirect_pc_o    = '0;
        end
    end

    // Count the cycles in which the PC register is frozen. The count wraps
    // naturally at 32 bits.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, stall_valid_o[0]};
    end

    // State, pending-redirect and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= RUN;
            pend_pc_q      <= '0;
            pend_trap_q    <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pend_pc_q      <= pend_pc_d;
            pend_trap_q    <= pend_trap_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 6-stage core (PC=0, IF=1, ID=2, EX=3, MEM=4, WB=5). It merges per-stage stall requests into the `stall_valid`/`flush_valid` vectors consumed by every stage register, including the PC register. It arbitrates the EX branch redirect against the MEM trap redirect, and delivers a redirect to the PC register only in a cycle where the PC register is write-enabled. A redirect that arrives while the pipe is stalled is buffered, never dropped. A free-running stall-cycle counter is exported for performance monitoring.

## Interface
- No parameters; widths come from `XLEN`/`XLEN_BUS` in sysconfig.v.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- if_stall_req_i  in  1  icache fetch outstanding.
- id_stall_req_i  in  1  load-use hazard.
- ex_stall_req_i  in  1  multi-cycle mul/div busy.
- mem_stall_req_i  in  1  dcache access outstanding.
- branch_pc_i  in  XLEN  branch target from EX.
- branch_pc_valid_i  in  1  EX branch redirect request.
- clint_pc_i  in  XLEN  trap/return target from MEM.
- clint_pc_valid_i  in  1  MEM trap redirect request.
- stall_valid_o  out  6  per-stage stall; bit i freezes stage i's output register.
- flush_valid_o  out  6  per-stage flush; bit i loads a bubble into stage i's output register.
- redirect_pc_o  out  XLEN  redirect target; drives the PC register's branch_pc input.
- redirect_valid_o  out  1  redirect strobe; drives the PC register's branch_pc_valid input.
- stall_cycles_o  out  32  count of cycles with stall_valid_o[0]=1.

## Operation
- Stall vector: k = highest index with an active request (IF=1, ID=2, EX=3, MEM=4). stall_valid_o[i]=1 for all i<=k. flush_valid_o[k+1]=1 inserts a bubble downstream; since k<=4, k+1<=5. With no request, stall_valid_o=0.
- flush_valid_o[0] is never asserted. The PC register treats it as a reset to the reset address.
- FSM states:
  - RUN: no redirect pending.
  - HOLD: registers pend_pc (XLEN) and pend_trap (1).
- RUN, no stall request, redirect input present:
  - Drive the redirect combinationally in the same cycle. Trap beats branch.
  - Trap: redirect_pc_o=clint_pc_i, flush_valid_o[4:1]=4'b1111.
  - Branch: redirect_pc_o=branch_pc_i, flush_valid_o[2:1]=2'b11.
  - State stays RUN.
- RUN, any stall request, redirect input present:
  - Capture the winner (trap over branch) into pend_pc/pend_trap and go to HOLD.
  - redirect_valid_o=0. The stall vector alone drives flush this cycle.
- HOLD, any stall request:
  - Keep waiting.
  - A new trap overwrites pend_pc and sets pend_trap=1.
  - A new branch is ignored.
- HOLD, no stall request (release cycle):
  - Drive redirect_valid_o=1 with pend_pc.
  - Flush [4:1] if pend_trap, else [2:1].
  - Return to RUN.
  - If clint_pc_valid_i is also high this cycle, the live trap wins: clint_pc_i is output with flush [4:1]. A live branch that cycle is ignored.
- Flush bits from a redirect are ORed with the stall-derived bubble bit, then masked with ~stall_valid_o.
- stall_cycles_o increments when stall_valid_o[0]=1 and wraps 0xFFFF_FFFF to 0.

## Timing
- Reset: rst=0 sampled at posedge puts state in RUN and clears pend_pc, pend_trap and stall_cycles_o.
- While rst=0, all combinational outputs are forced to 0.
- Reset mid-HOLD discards the pending redirect.
- Stall/flush outputs are purely combinational from current requests plus state; zero-cycle latency.
- Unstalled redirect: same-cycle output, exactly 1 cycle long.
- Stalled redirect: captured at the posedge ending cycle N. Output in the first cycle M>N with no stall request, for exactly 1 cycle; state is RUN at M+1.
- redirect_valid_o is never high while stall_valid_o[0]=1. This guarantees the PC register's write enable is set whenever a redirect is presented.
- Counter updates at posedge, so stall_cycles_o lags the stall by one cycle.

## Test plan
- Reset and idle:
  - Stimulus: rst low 2 cycles, then no requests.
  - Required: all outputs 0; stall_cycles_o=0.
- Stall decode:
  - Stimulus: mem_stall_req_i alone.
  - Required: stall=6'b011111, flush=6'b100000.
  - Stimulus: id_stall_req_i plus if_stall_req_i.
  - Required: stall=6'b000111, flush=6'b001000.
- Simultaneous redirects:
  - Stimulus: in RUN, branch 0x8000_0100 and trap 0x8000_0400 in the same cycle.
  - Required: redirect_pc_o=0x8000_0400, flush=6'b011110, valid for 1 cycle.
- Buffered redirect:
  - Stimulus: branch 0x8000_0200 during a 3-cycle if_stall_req_i.
  - Required: redirect_valid_o=0 during the stall; in the release cycle redirect_pc_o=0x8000_0200, flush=6'b000110; stall_cycles_o=3 one cycle later.
- Trap overwrite in HOLD:
  - Stimulus: pending branch, then trap 0x8000_0004 while still stalled.
  - Required: release drives 0x8000_0004 with flush [4:1].
- Reset mid-HOLD and counter wrap:
  - Stimulus: rst low during HOLD.
  - Required: no redirect after reset.
  - Stimulus: force the counter to 0xFFFF_FFFF, then one stalled cycle.
  - Required: stall_cycles_o=0.
